sonar_ranger_ctrl: RTL and testbench

MMIO slot core that sequences an HC-SR04-style ultrasonic ranger on the PMOD JB pins (sonar_trig, sonar_echo) for the MicroBlaze MCS sampler system. It issues trigger pulses, times the echo width in clock cycles and enforces a timeout. It supports one-shot and continuous (periodic) ranging and exposes status, result and sample count to firmware through the standard FPro slot bus.

---
 rtl/sonar_ranger_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sonar_ranger_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ranger_ctrl.sv
// FPro slot core sequencing an HC-SR04-style ultrasonic ranger: trigger pulse,
// echo-width measurement with timeout, one-shot or periodic operation.
module sonar_ranger_ctrl #(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned TRIG_US      = 10,
  parameter int unsigned TIMEOUT_US   = 30000,
  parameter int unsigned CNT_W        = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        sonar_trig,
  input  logic        sonar_echo
);

  localparam int unsigned TRIG_CYC = CLK_FREQ_MHZ * TRIG_US;
  localparam int unsigned TO_CYC   = CLK_FREQ_MHZ * TIMEOUT_US;
  localparam logic [CNT_W-1:0] TrigLast = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] EchoMax  = CNT_W'(TO_CYC);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StHoldoff} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pcnt_q, pcnt_d, pcnt_inc;
  logic [31:0]       period_q;
  logic              cont_q, go_q;
  logic              done_q, timeout_q;
  logic [CNT_W-1:0]  result_q;
  logic [15:0]       sample_cnt_q;
  logic [1:0]        sync_q;
  logic              echo_d_q;
  logic              echo_s, rise, fall;
  logic              wr0, wr1, wr2;
  logic              sample_ok, sample_to;
  logic              unused_bits;

  assign unused_bits = ^{read, addr[4:2]};

  assign wr0 = cs & write & (addr[1:0] == 2'd0);
  assign wr1 = cs & write & (addr[1:0] == 2'd1);
  assign wr2 = cs & write & (addr[1:0] == 2'd2);

  assign echo_s = sync_q[1];
  assign rise   = echo_s & ~echo_d_q;
  assign fall   = ~echo_s & echo_d_q;

  assign pcnt_inc   = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;
  assign sonar_trig = (state_q == StTrig);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_inc;
    sample_ok = 1'b0;
    sample_to = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_q) begin
          state_d = StTrig;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
      end
      StTrig: begin
        if (cnt_q == TrigLast) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitRise: begin
        if (rise) begin
          // The rise cycle is itself the first high cycle, keeping widths exact.
          state_d = StMeasure;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == WaitLast) begin
          state_d   = StHoldoff;
          sample_to = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMeasure: begin
        if (fall) begin
          state_d   = StHoldoff;
          sample_ok = 1'b1;
        end else if (cnt_q == EchoMax) begin
          state_d   = StHoldoff;
          sample_to = 1'b1;
        end else if (echo_s) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        // Compare the value pcnt takes this cycle so trigger edges are exactly period apart.
        if (pcnt_inc >= period_q) begin
          if (cont_q) begin
            state_d = StTrig;
            cnt_d   = '0;
            pcnt_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      period_q     <= '0;
      cont_q       <= 1'b0;
      go_q         <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      sample_cnt_q <= '0;
      sync_q       <= '0;
      echo_d_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      sync_q   <= {sync_q[0], sonar_echo};
      echo_d_q <= echo_s;
      go_q     <= wr0 & wr_data[0];
      if (wr0) cont_q <= wr_data[1];
      if (wr1) period_q <= wr_data;
      if (sample_ok || sample_to) begin
        done_q       <= 1'b1;
        timeout_q    <= sample_to;
        result_q     <= sample_ok ? cnt_q : '0;
        sample_cnt_q <= sample_cnt_q + 16'd1;
      end else if (wr2) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr[1:0])
      2'd0: rd_data = {29'b0, timeout_q, done_q, (state_q != StIdle)};
      2'd1: rd_data = period_q;
      2'd2: rd_data = 32'(result_q);
      2'd3: rd_data = {16'b0, sample_cnt_q};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_sonar_ranger_ctrl.sv
// Self-checking bench for sonar_ranger_ctrl using scaled-down timing parameters.
module tb_sonar_ranger_ctrl;

  localparam int CLK_MHZ  = 2;
  localparam int TRIG_US  = 5;
  localparam int TO_US    = 200;
  localparam int TRIG_CYC = CLK_MHZ * TRIG_US;
  localparam int TO_CYC   = CLK_MHZ * TO_US;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        sonar_trig;
  logic        sonar_echo = 1'b0;

  sonar_ranger_ctrl #(
    .CLK_FREQ_MHZ(CLK_MHZ),
    .TRIG_US     (TRIG_US),
    .TIMEOUT_US  (TO_US),
    .CNT_W       (22)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs        (cs),
    .read      (rd),
    .write     (wr),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .sonar_trig(sonar_trig),
    .sonar_echo(sonar_echo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int trig_rises = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sonar_trig) trig_rises <= trig_rises + 1;

  typedef struct {
    int delay;
    int width;
    int exp_result;
    int exp_to;
  } vec_t;

  typedef struct {
    int result;
    int status;
    int cnt;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    addr    = a[4:0];
    wr_data = d;
    cs      = 1'b1;
    wr      = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
    wr = 1'b0;
  endtask

  task automatic bus_read(input int a, output int d);
    addr = a[4:0];
    cs   = 1'b1;
    rd   = 1'b1;
    #1;
    d  = int'(rd_data);
    cs = 1'b0;
    rd = 1'b0;
  endtask

  task automatic wait_trig_rise(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sonar_trig) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_trig_fall(input int bound, output int width);
    width = 0;
    while (sonar_trig && width < bound) begin
      width++;
      tick(1);
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int d;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      bus_read(0, d);
      if (d[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic push_exp(input int result, input int to);
    exp_t e;
    model_cnt  = (model_cnt + 1) % 65536;
    e.result   = result;
    e.status   = to ? 6 : 2;
    e.cnt      = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag, input bit with_status);
    exp_t e;
    int   d;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      bus_read(2, d);
      check({tag, "_result"}, d, e.result);
      bus_read(3, d);
      check({tag, "_count"}, d, e.cnt);
      if (with_status) begin
        bus_read(0, d);
        check({tag, "_status"}, d, e.status);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int d, w, t0, rises0;
    int rise_cyc[5];

    vecs[0] = '{5, 150, 150, 0};
    vecs[1] = '{0, 1, 1, 0};
    vecs[2] = '{0, 0, 0, 1};
    vecs[3] = '{3, 399, 399, 0};
    vecs[4] = '{2, 450, 0, 1};
    vecs[5] = '{385, 5, 5, 0};
    vecs[6] = '{420, 20, 0, 1};

    // Reset state
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("rst_trig", int'(sonar_trig), 0);
    for (int a = 0; a < 4; a++) begin
      bus_read(a, d);
      check($sformatf("rst_reg%0d", a), d, 0);
    end

    // One-shot vectors, period 0
    foreach (vecs[i]) begin
      push_exp(vecs[i].exp_result, vecs[i].exp_to);
      bus_write(0, 32'h1);
      wait_trig_rise(20, ok);
      check($sformatf("v%0d_trig_start", i), int'(ok), 1);
      wait_trig_fall(100, w);
      check($sformatf("v%0d_trig_width", i), w, TRIG_CYC);
      if (vecs[i].width > 0) begin
        tick(vecs[i].delay);
        sonar_echo = 1'b1;
        tick(vecs[i].width);
        sonar_echo = 1'b0;
      end
      wait_idle(2000, ok);
      check($sformatf("v%0d_idle", i), int'(ok), 1);
      pop_check($sformatf("v%0d", i), 1'b1);
      tick(5);
    end

    // Timeout latency with no echo, then clear
    push_exp(0, 1);
    bus_write(0, 32'h1);
    wait_trig_rise(20, ok);
    wait_trig_fall(100, w);
    t0 = 0;
    bus_write(2, 32'h0);
    t0 = 1;
    for (int i = 0; i < TO_CYC + 50; i++) begin
      bus_read(0, d);
      if (d[1]) break;
      tick(1);
      t0++;
    end
    check_range("to_latency", t0, TO_CYC - 1, TO_CYC + 2);
    tick(3);
    pop_check("to", 1'b1);
    bus_write(2, 32'h0);
    bus_read(0, d);
    check("to_clear", d, 0);

    // Continuous ranging, then cont cleared during the fifth shot
    bus_write(1, 32'd200);
    bus_read(1, d);
    check("period_rd", d, 200);
    bus_write(0, 32'h3);
    for (int k = 0; k < 5; k++) begin
      wait_trig_rise(400, ok);
      check($sformatf("c%0d_trig_start", k), int'(ok), 1);
      rise_cyc[k] = cyc;
      if (k > 0) check($sformatf("c%0d_spacing", k), rise_cyc[k] - rise_cyc[k-1], 200);
      if (k == 4) bus_write(0, 32'h0);
      wait_trig_fall(100, w);
      tick(5);
      sonar_echo = 1'b1;
      tick(50);
      sonar_echo = 1'b0;
      push_exp(50, 0);
      tick(6);
      pop_check($sformatf("c%0d", k), 1'b0);
    end
    rises0 = trig_rises;
    wait_idle(400, ok);
    check("c_idle", int'(ok), 1);
    tick(300);
    check("c_no_retrig", trig_rises - rises0, 0);
    bus_read(0, d);
    check("c_status", d, 2);
    bus_write(1, 32'd0);

    // Echo stuck high through trigger; go while busy is ignored
    sonar_echo = 1'b1;
    tick(5);
    rises0 = trig_rises;
    push_exp(0, 1);
    bus_write(0, 32'h1);
    wait_trig_rise(20, ok);
    wait_trig_fall(100, w);
    tick(20);
    bus_write(0, 32'h1);
    wait_idle(TO_CYC + 100, ok);
    check("stuck_idle", int'(ok), 1);
    tick(50);
    check("stuck_trig_count", trig_rises - rises0, 1);
    pop_check("stuck", 1'b1);
    sonar_echo = 1'b0;
    tick(5);

    // Reset mid-TRIG
    bus_write(0, 32'h1);
    wait_trig_rise(20, ok);
    tick(3);
    reset_n = 1'b0;
    #1;
    check("rst_trig_async", int'(sonar_trig), 0);
    bus_read(0, d);
    check("rst_trig_busy", d, 0);
    tick(2);
    reset_n = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    tick(2);
    check("rst_trig_after", int'(sonar_trig), 0);

    // Good sample, then reset mid-MEASURE must clear the result
    push_exp(40, 0);
    bus_write(0, 32'h1);
    wait_trig_rise(20, ok);
    wait_trig_fall(100, w);
    tick(2);
    sonar_echo = 1'b1;
    tick(40);
    sonar_echo = 1'b0;
    wait_idle(100, ok);
    pop_check("pre_rst", 1'b1);
    bus_write(0, 32'h1);
    wait_trig_rise(20, ok);
    wait_trig_fall(100, w);
    tick(2);
    sonar_echo = 1'b1;
    tick(30);
    reset_n = 1'b0;
    #1;
    check("rst_meas_trig", int'(sonar_trig), 0);
    tick(2);
    reset_n = 1'b1;
    sonar_echo = 1'b0;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(a, d);
      check($sformatf("rst_meas_reg%0d", a), d, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
